axi_rd_arbiter: RTL and testbench

- Shares one 64-bit AXI3 read port (HP port into DDR) between two read requesters, e.g. two pattern/overlay sources fetching frame data.
- Arbitrates the AR channel round-robin and registers the granted request in a one-entry buffer.
- Tags the outgoing ARID with the source index and routes R beats back by RID.
- Tracks outstanding bursts per source and throttles each source at a configured limit.

---
 rtl/axi_rd_arbiter.sv | 176 +++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Two-source AXI3 read arbiter: round-robin AR grant into a one-entry buffer,
// ARID tagged with the source index, R beats routed back by RID[5].
module axi_rd_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              s0_arvalid,
    output logic              s0_arready,
    input  logic [ADDR_W-1:0] s0_araddr,
    input  logic [3:0]        s0_arlen,
    input  logic [4:0]        s0_arid,
    input  logic [2:0]        s0_arsize,
    input  logic [1:0]        s0_arburst,
    output logic              s0_rvalid,
    input  logic              s0_rready,
    output logic [DATA_W-1:0] s0_rdata,
    output logic [1:0]        s0_rresp,
    output logic              s0_rlast,
    output logic [5:0]        s0_rid,

    input  logic              s1_arvalid,
    output logic              s1_arready,
    input  logic [ADDR_W-1:0] s1_araddr,
    input  logic [3:0]        s1_arlen,
    input  logic [4:0]        s1_arid,
    input  logic [2:0]        s1_arsize,
    input  logic [1:0]        s1_arburst,
    output logic              s1_rvalid,
    input  logic              s1_rready,
    output logic [DATA_W-1:0] s1_rdata,
    output logic [1:0]        s1_rresp,
    output logic              s1_rlast,
    output logic [5:0]        s1_rid,

    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [3:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic [5:0]        m_axi_arid,
    output logic [1:0]        m_axi_arlock,
    output logic [3:0]        m_axi_arcache,
    output logic [2:0]        m_axi_arprot,
    output logic [3:0]        m_axi_arqos,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic [5:0]        m_axi_rid
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTST);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic [3:0]        cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [3:0]        arlen_q, arlen_d;
    logic [2:0]        arsize_q, arsize_d;
    logic [1:0]        arburst_q, arburst_d;
    logic [5:0]        arid_q, arid_d;

    logic elig0, elig1, grant, win;
    logic rd_done, dec0, dec1, inc0, inc1;

    assign elig0 = s0_arvalid && (cnt0_q < MAX_CNT);
    assign elig1 = s1_arvalid && (cnt1_q < MAX_CNT);
    // No handshake while reset is held, so nothing is accepted and then lost.
    assign grant = (state_q == IDLE) && (elig0 || elig1) && !rst_i;

    // Winner: the eligible source that was not granted last, else the only one.
    always_comb begin
        if (elig0 && elig1) win = ~last_q;
        else                win = elig1;
    end

    // NOTE: sequential state uses <= only; comb blocks use = with a default first, so no latches.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = HOLD;
            HOLD:    if (m_axi_arready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s0_arready    = grant && !win;
        s1_arready    = grant && win;
        m_axi_arvalid = (state_q == HOLD);
    end

    assign rd_done = m_axi_rvalid && m_axi_rready && m_axi_rlast;
    assign inc0    = grant && !win;
    assign inc1    = grant && win;
    // A spurious RLAST at zero is ignored rather than wrapping the counter.
    assign dec0    = rd_done && !m_axi_rid[5] && (cnt0_q != 4'd0);
    assign dec1    = rd_done &&  m_axi_rid[5] && (cnt1_q != 4'd0);

    always_comb begin
        last_d    = last_q;
        cnt0_d    = cnt0_q + {3'd0, inc0} - {3'd0, dec0};
        cnt1_d    = cnt1_q + {3'd0, inc1} - {3'd0, dec1};
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arburst_d = arburst_q;
        arid_d    = arid_q;
        if (grant) begin
            last_d    = win;
            araddr_d  = win ? s1_araddr  : s0_araddr;
            arlen_d   = win ? s1_arlen   : s0_arlen;
            arsize_d  = win ? s1_arsize  : s0_arsize;
            arburst_d = win ? s1_arburst : s0_arburst;
            arid_d    = {win, (win ? s1_arid : s0_arid)};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
            cnt0_q <= 4'd0;
            cnt1_q <= 4'd0;
        end else begin
            last_q <= last_d;
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    // NOTE: the request buffer is not reset; it is only observed while m_axi_arvalid is high.
    always_ff @(posedge clk_i) begin
        araddr_q  <= araddr_d;
        arlen_q   <= arlen_d;
        arsize_q  <= arsize_d;
        arburst_q <= arburst_d;
        arid_q    <= arid_d;
    end

    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = arsize_q;
    assign m_axi_arburst = arburst_q;
    assign m_axi_arid    = arid_q;
    assign m_axi_arlock  = 2'd0;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arqos   = 4'd0;

    // R path is purely combinational: only rvalid and rready are steered.
    assign s0_rvalid    = m_axi_rvalid && !m_axi_rid[5];
    assign s1_rvalid    = m_axi_rvalid &&  m_axi_rid[5];
    assign m_axi_rready = m_axi_rid[5] ? s1_rready : s0_rready;
    assign s0_rdata     = m_axi_rdata;
    assign s1_rdata     = m_axi_rdata;
    assign s0_rresp     = m_axi_rresp;
    assign s1_rresp     = m_axi_rresp;
    assign s0_rlast     = m_axi_rlast;
    assign s1_rlast     = m_axi_rlast;
    assign s0_rid       = {1'b0, m_axi_rid[4:0]};
    assign s1_rid       = {1'b0, m_axi_rid[4:0]};

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: AR payloads are queued when a source is
// accepted and compared at the master handshake; R beats are queued when driven.
module tb_axi_rd_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              s0_arvalid = 0, s1_arvalid = 0;
    logic              s0_arready, s1_arready;
    logic [ADDR_W-1:0] s0_araddr = 0, s1_araddr = 0;
    logic [3:0]        s0_arlen = 0, s1_arlen = 0;
    logic [4:0]        s0_arid = 0, s1_arid = 0;
    logic [2:0]        s0_arsize = 0, s1_arsize = 0;
    logic [1:0]        s0_arburst = 0, s1_arburst = 0;
    logic              s0_rvalid, s1_rvalid;
    logic              s0_rready = 0, s1_rready = 0;
    logic [DATA_W-1:0] s0_rdata, s1_rdata;
    logic [1:0]        s0_rresp, s1_rresp;
    logic              s0_rlast, s1_rlast;
    logic [5:0]        s0_rid, s1_rid;
    logic              m_axi_arvalid;
    logic              m_axi_arready = 0;
    logic [ADDR_W-1:0] m_axi_araddr;
    logic [3:0]        m_axi_arlen;
    logic [2:0]        m_axi_arsize;
    logic [1:0]        m_axi_arburst;
    logic [5:0]        m_axi_arid;
    logic [1:0]        m_axi_arlock;
    logic [3:0]        m_axi_arcache;
    logic [2:0]        m_axi_arprot;
    logic [3:0]        m_axi_arqos;
    logic              m_axi_rvalid = 0;
    logic              m_axi_rready;
    logic [DATA_W-1:0] m_axi_rdata = 0;
    logic [1:0]        m_axi_rresp = 0;
    logic              m_axi_rlast = 0;
    logic [5:0]        m_axi_rid = 0;

    axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr),
        .s0_arlen(s0_arlen), .s0_arid(s0_arid), .s0_arsize(s0_arsize), .s0_arburst(s0_arburst),
        .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rdata(s0_rdata),
        .s0_rresp(s0_rresp), .s0_rlast(s0_rlast), .s0_rid(s0_rid),
        .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr),
        .s1_arlen(s1_arlen), .s1_arid(s1_arid), .s1_arsize(s1_arsize), .s1_arburst(s1_arburst),
        .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rdata(s1_rdata),
        .s1_rresp(s1_rresp), .s1_rlast(s1_rlast), .s1_rid(s1_rid),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arid(m_axi_arid), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rid(m_axi_rid)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [5:0]        id;
        logic [ADDR_W-1:0] addr;
        logic [3:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } ar_exp_t;

    typedef struct {
        logic              rv0;
        logic              rv1;
        logic [5:0]        rid;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
        logic              rready;
    } r_exp_t;

    ar_exp_t ar_q[$];
    r_exp_t  r_q[$];
    int      vectors = 0;
    int      miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        ar_q.delete();
        r_q.delete();
    endtask

    // Drive one R beat and record what each source should see for it.
    task automatic drive_r(input logic [5:0] rid, input logic [63:0] data, input logic last);
        r_exp_t e;
        m_axi_rvalid = 1'b1;
        m_axi_rid    = rid;
        m_axi_rdata  = data;
        m_axi_rresp  = data[1:0];
        m_axi_rlast  = last;
        e.rv0    = !rid[5];
        e.rv1    = rid[5];
        e.rid    = {1'b0, rid[4:0]};
        e.data   = data;
        e.resp   = data[1:0];
        e.last   = last;
        e.rready = rid[5] ? s1_rready : s0_rready;
        r_q.push_back(e);
    endtask

    task automatic clear_r();
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
    endtask

    // Monitor samples on the falling edge, half a cycle away from the active edge.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (s0_arvalid && s0_arready)
                ar_q.push_back('{{1'b0, s0_arid}, s0_araddr, s0_arlen, s0_arsize, s0_arburst});
            else if (s1_arvalid && s1_arready)
                ar_q.push_back('{{1'b1, s1_arid}, s1_araddr, s1_arlen, s1_arsize, s1_arburst});
            if (m_axi_arvalid && m_axi_arready) begin
                if (ar_q.size() == 0) begin
                    check("ar_unexpected", 64'd1, 64'd0);
                end else begin
                    ar_exp_t a;
                    a = ar_q.pop_front();
                    check("ar_id", 64'(m_axi_arid), 64'(a.id));
                    check("ar_addr", 64'(m_axi_araddr), 64'(a.addr));
                    check("ar_len", 64'(m_axi_arlen), 64'(a.len));
                    check("ar_size", 64'(m_axi_arsize), 64'(a.size));
                    check("ar_burst", 64'(m_axi_arburst), 64'(a.burst));
                end
            end
            if (m_axi_rvalid) begin
                if (r_q.size() == 0) begin
                    check("r_unexpected", 64'd1, 64'd0);
                end else begin
                    r_exp_t r;
                    r = r_q.pop_front();
                    check("r_s0_rvalid", 64'(s0_rvalid), 64'(r.rv0));
                    check("r_s1_rvalid", 64'(s1_rvalid), 64'(r.rv1));
                    check("r_s0_rid", 64'(s0_rid), 64'(r.rid));
                    check("r_s1_rid", 64'(s1_rid), 64'(r.rid));
                    check("r_s0_rdata", s0_rdata, r.data);
                    check("r_s1_rdata", s1_rdata, r.data);
                    check("r_resp", 64'({s1_rresp, s0_rresp}), 64'({r.resp, r.resp}));
                    check("r_last", 64'({s1_rlast, s0_rlast}), 64'({r.last, r.last}));
                    check("r_rready", 64'(m_axi_rready), 64'(r.rready));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_src;

        // Reset: arready must stay low even with a request pending.
        tick();
        s0_arvalid = 1'b1;
        #1;
        check("rst_s0_arready", 64'(s0_arready), 64'd0);
        check("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        tick();
        rst_i = 1'b0;
        s0_arvalid = 1'b0;
        #1;
        check("rst_cnt0", 64'(dut.cnt0_q), 64'd0);
        check("rst_cnt1", 64'(dut.cnt1_q), 64'd0);
        check("rst_arvalid2", 64'(m_axi_arvalid), 64'd0);

        // Single s0 request.
        s0_araddr = 32'h2100_0000; s0_arlen = 4'd15; s0_arid = 5'd3;
        s0_arsize = 3'd3; s0_arburst = 2'd1; s0_arvalid = 1'b1;
        #1;
        check("t1_s0_arready", 64'(s0_arready), 64'd1);
        check("t1_s1_arready", 64'(s1_arready), 64'd0);
        check("t1_arvalid_pre", 64'(m_axi_arvalid), 64'd0);
        check("t1_tieoffs", 64'({m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos}), 64'd0);
        tick();
        s0_arvalid = 1'b0;
        #1;
        check("t1_arvalid", 64'(m_axi_arvalid), 64'd1);
        check("t1_arid", 64'(m_axi_arid), 64'h03);
        check("t1_araddr", 64'(m_axi_araddr), 64'h2100_0000);
        check("t1_cnt0", 64'(dut.cnt0_q), 64'd1);
        check("t1_s0_arready_hold", 64'(s0_arready), 64'd0);
        m_axi_arready = 1'b1;
        tick();
        #1;
        check("t1_arvalid_drop", 64'(m_axi_arvalid), 64'd0);
        m_axi_arready = 1'b0;

        // Both sources continuously requesting: 0,1,0,1,... one grant per 2 cycles.
        do_reset();
        s0_araddr = 32'h1000_0000; s0_arid = 5'd1; s0_arlen = 4'd7;
        s1_araddr = 32'h2000_0000; s1_arid = 5'd2; s1_arlen = 4'd3;
        s0_arvalid = 1'b1; s1_arvalid = 1'b1; m_axi_arready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            exp_src = (k / 2) % 2;
            if (k % 2 == 0) begin
                check("rr_s0_arready", 64'(s0_arready), 64'(exp_src == 0));
                check("rr_s1_arready", 64'(s1_arready), 64'(exp_src == 1));
                check("rr_arvalid_idle", 64'(m_axi_arvalid), 64'd0);
            end else begin
                check("rr_arvalid_hold", 64'(m_axi_arvalid), 64'd1);
                check("rr_arid_src", 64'(m_axi_arid[5]), 64'(exp_src));
                check("rr_no_grant_hold", 64'({s1_arready, s0_arready}), 64'd0);
                if (exp_src == 0) begin s0_araddr += 32'h100; s0_arid += 5'd1; end
                else              begin s1_araddr += 32'h100; s1_arid += 5'd1; end
            end
            tick();
        end
        s0_arvalid = 1'b0; s1_arvalid = 1'b0; m_axi_arready = 1'b0;
        #1;
        check("rr_cnt0", 64'(dut.cnt0_q), 64'd3);
        check("rr_cnt1", 64'(dut.cnt1_q), 64'd3);

        // 16-beat burst back to s1; counter drops only on the last beat.
        s1_rready = 1'b1; s0_rready = 1'b0;
        for (int b = 0; b < 16; b++) begin
            drive_r(6'h23, {$urandom(), $urandom()}, b == 15);
            #1;
            if (b == 15) check("r_cnt1_pre", 64'(dut.cnt1_q), 64'd3);
            tick();
        end
        clear_r();
        #1;
        check("r_cnt1_post", 64'(dut.cnt1_q), 64'd2);
        check("r_cnt0_untouched", 64'(dut.cnt0_q), 64'd3);

        // Throttle at MAX_OUTST=4.
        do_reset();
        s0_araddr = 32'h4000_0000; s0_arid = 5'd0; s0_arvalid = 1'b1; m_axi_arready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            #1;
            check("thr_grant", 64'(s0_arready), 64'd1);
            tick();
            #1;
            check("thr_arvalid", 64'(m_axi_arvalid), 64'd1);
            s0_araddr += 32'h800;
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            #1;
            check("thr_blocked", 64'(s0_arready), 64'd0);
            check("thr_no_arvalid", 64'(m_axi_arvalid), 64'd0);
            tick();
        end
        s0_rready = 1'b1;
        drive_r(6'h00, 64'h1111_2222_3333_4444, 1'b1);
        #1;
        check("thr_same_cycle_blocked", 64'(s0_arready), 64'd0);
        tick();
        clear_r();
        #1;
        check("thr_regrant", 64'(s0_arready), 64'd1);
        tick();
        s0_arvalid = 1'b0;
        #1;
        check("thr_regrant_arvalid", 64'(m_axi_arvalid), 64'd1);
        tick();

        // AR backpressure: buffer holds while the source payload changes.
        m_axi_arready = 1'b0;
        s1_araddr = 32'h3000_0040; s1_arlen = 4'd7; s1_arid = 5'h1f;
        s1_arsize = 3'd3; s1_arburst = 2'd1; s1_arvalid = 1'b1;
        #1;
        check("bp_s1_arready", 64'(s1_arready), 64'd1);
        tick();
        s1_arvalid = 1'b0; s1_araddr = 32'hDEAD_BEEF; s1_arlen = 4'd0; s1_arid = 5'd0;
        for (int c = 0; c < 10; c++) begin
            #1;
            check("bp_arvalid", 64'(m_axi_arvalid), 64'd1);
            check("bp_araddr", 64'(m_axi_araddr), 64'h3000_0040);
            check("bp_arlen", 64'(m_axi_arlen), 64'd7);
            check("bp_arid", 64'(m_axi_arid), 64'h3f);
            tick();
        end
        // R backpressure from s1 must reach m_axi_rready.
        s0_rready = 1'b1; s1_rready = 1'b0;
        drive_r(6'h20, 64'hA5A5_0000_5A5A_0001, 1'b1);
        #1;
        check("bp_m_rready", 64'(m_axi_rready), 64'd0);
        tick();
        clear_r();
        #1;
        check("bp_cnt1_no_hs", 64'(dut.cnt1_q), 64'd1);
        m_axi_arready = 1'b1;
        tick();
        #1;
        check("bp_release", 64'(m_axi_arvalid), 64'd0);
        m_axi_arready = 1'b0;

        // Same-cycle increment and decrement on cnt0, then reset during HOLD.
        drive_r(6'h00, 64'h0, 1'b1);
        tick();
        clear_r();
        #1;
        check("sc_cnt0_pre", 64'(dut.cnt0_q), 64'd3);
        s0_arvalid = 1'b1;
        drive_r(6'h05, 64'h0BAD_F00D_0000_0002, 1'b1);
        #1;
        check("sc_s0_arready", 64'(s0_arready), 64'd1);
        tick();
        s0_arvalid = 1'b0;
        clear_r();
        #1;
        check("sc_cnt0_same", 64'(dut.cnt0_q), 64'd3);
        check("sc_arvalid", 64'(m_axi_arvalid), 64'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        ar_q.delete();
        #1;
        check("hold_rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        check("hold_rst_cnt0", 64'(dut.cnt0_q), 64'd0);
        check("hold_rst_cnt1", 64'(dut.cnt1_q), 64'd0);

        // Spurious RLAST at zero must not underflow.
        drive_r(6'h00, 64'h0, 1'b1);
        tick();
        clear_r();
        #1;
        check("uf_cnt0", 64'(dut.cnt0_q), 64'd0);

        tick();
        check("sb_ar_empty", 64'(ar_q.size()), 64'd0);
        check("sb_r_empty", 64'(r_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
